// File: rtl/msg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : msg_write_arbiter
// Purpose  : Round-robin arbiter that gives one message producer at a time
//            the MSG_FIFO write port. It checks free space before granting,
//            so each message goes into the FIFO as one contiguous burst.
//            Optional header word: define MSG_WRITE_ARBITER_HDR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module msg_write_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int MAX_LEN    = 4,
   parameter int FIFO_DEPTH = 256,
   parameter int RESERVE    = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [3*NUM_REQ-1:0]  req_len,
   input  logic [32*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]    gnt,
   output logic                  word_ack,
   output logic [NUM_REQ-1:0]    done,
   output logic                  fifo_wrreq,
   output logic [31:0]           fifo_data,
   input  logic [7:0]            fifo_usedw,
   input  logic                  fifo_flush,
   output logic                  busy
);

   localparam int               c_idx_w   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [9:0]       c_limit   = 10'(FIFO_DEPTH - RESERVE);
   localparam logic [2:0]       c_max_len = (MAX_LEN >= 7) ? 3'd7 : 3'(MAX_LEN);
   localparam logic [NUM_REQ-1:0] c_one   = NUM_REQ'(1);

   localparam logic [1:0] c_st_idle  = 2'd0;
`ifdef MSG_WRITE_ARBITER_HDR_EN
   localparam logic [1:0] c_st_hdr   = 2'd1;
`endif
   localparam logic [1:0] c_st_write = 2'd2;
   localparam logic [1:0] c_st_done  = 2'd3;

   logic [1:0]         r_state;
   logic [NUM_REQ-1:0] r_gnt;
   logic [NUM_REQ-1:0] r_done;
   logic [c_idx_w-1:0] r_ptr;
   logic [2:0]         r_len;
   logic [2:0]         r_cnt;
`ifdef MSG_WRITE_ARBITER_HDR_EN
   logic [c_idx_w-1:0] r_idx;
   logic [15:0]        r_seq;
`endif

   logic [2:0]         w_eff_len [NUM_REQ];
   logic [NUM_REQ-1:0] w_elig;
   logic               w_found;
   logic [c_idx_w-1:0] w_sel;
   logic [31:0]        w_mux;

   // The sum is formed at 10 bits so a nearly full FIFO can never wrap into "room".
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
      logic [2:0] w_len;
      logic [9:0] w_need;
      assign w_len        = req_len[3*i +: 3];
      assign w_eff_len[i] = (w_len > c_max_len) ? c_max_len : w_len;
`ifdef MSG_WRITE_ARBITER_HDR_EN
      assign w_need       = {7'd0, w_eff_len[i]} + 10'd1;
`else
      assign w_need       = {7'd0, w_eff_len[i]};
`endif
      assign w_elig[i]    = req[i] && (w_len != 3'd0) &&
                            (({2'b00, fifo_usedw} + w_need) <= c_limit);
   end

   // Scan downward in distance so the closest eligible index from r_ptr wins.
   always_comb begin
      int j;
      w_found = 1'b0;
      w_sel   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = int'(r_ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (w_elig[j]) begin
            w_found = 1'b1;
            w_sel   = c_idx_w'(j);
         end
      end
   end

   always_comb begin
      w_mux = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_gnt[i]) w_mux = req_data[32*i +: 32];
      end
   end

   always_comb begin
      fifo_wrreq = 1'b0;
      word_ack   = 1'b0;
      fifo_data  = '0;
      if (r_state == c_st_write) begin
         fifo_wrreq = 1'b1;
         word_ack   = 1'b1;
         fifo_data  = w_mux;
      end
`ifdef MSG_WRITE_ARBITER_HDR_EN
      else if (r_state == c_st_hdr) begin
         fifo_wrreq = 1'b1;
         fifo_data  = {8'hA5, 4'(r_idx), 4'(r_len), r_seq};
      end
`endif
   end

   assign gnt  = r_gnt;
   assign done = r_done;
   assign busy = (r_state != c_st_idle);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= c_st_idle;
         r_gnt   <= '0;
         r_done  <= '0;
         r_ptr   <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
`ifdef MSG_WRITE_ARBITER_HDR_EN
         r_idx   <= '0;
         r_seq   <= '0;
`endif
      end else begin
         r_done <= '0;
         case (r_state)
            c_st_idle: begin
               if (w_found) begin
                  r_gnt <= c_one << w_sel;
                  r_len <= w_eff_len[w_sel];
                  r_cnt <= '0;
                  r_ptr <= (w_sel == c_idx_w'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
`ifdef MSG_WRITE_ARBITER_HDR_EN
                  r_idx   <= w_sel;
                  r_state <= c_st_hdr;
`else
                  r_state <= c_st_write;
`endif
               end
            end
`ifdef MSG_WRITE_ARBITER_HDR_EN
            c_st_hdr: begin
               if (fifo_flush) begin
                  r_gnt   <= '0;
                  r_state <= c_st_idle;
               end else begin
                  r_state <= c_st_write;
               end
            end
`endif
            c_st_write: begin
               if (fifo_flush) begin
                  r_gnt   <= '0;
                  r_cnt   <= '0;
                  r_state <= c_st_idle;
               end else if (r_cnt == r_len - 3'd1) begin
                  r_done  <= r_gnt;
                  r_gnt   <= '0;
                  r_cnt   <= '0;
                  r_state <= c_st_done;
               end else begin
                  r_cnt <= r_cnt + 3'd1;
               end
            end
            c_st_done: begin
               // One idle-write cycle so fifo_usedw reflects the burst before re-arbitrating.
`ifdef MSG_WRITE_ARBITER_HDR_EN
               r_seq   <= r_seq + 16'd1;
`endif
               r_state <= c_st_idle;
            end
            default: r_state <= c_st_idle;
         endcase
      end
   end

endmodule
`default_nettype wire
